// File: rtl/usb_data_buffer.sv
// Byte-wide FIFO shared by the AHB host side (1/2/4 bytes per cycle) and the USB packet engines (1 byte per cycle).
// Optional sticky error flag output enabled by defining USB_DATA_BUFFER_ERR_EN.
module usb_data_buffer #(
  parameter int DEPTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [1:0]  get_rx_data,
  input  logic [1:0]  store_tx_data,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  input  logic        clear_data_buffer,
  input  logic        store_rx_packet_data,
  input  logic [7:0]  rx_packet_data,
  input  logic        get_tx_packet_data,
  output logic [7:0]  tx_packet_data,
  output logic [7:0]  buffer_occupancy
`ifdef USB_DATA_BUFFER_ERR_EN
  ,
  output logic        buffer_error
`endif
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  // Push/pop semantics: requests carry no ready. Every request is accepted at
  // the edge but truncated to what fits (push) or what is stored (pop); peek
  // outputs show the bytes that a pop at the coming edge will consume.

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [7:0]       occ;

  logic [2:0] host_push;
  logic [2:0] host_pop;
  logic [2:0] p_req;
  logic [2:0] q_req;
  logic [2:0] p;
  logic [2:0] q;
  logic [7:0] free;
  logic       use_host_push;

  function automatic logic [2:0] n_bytes(input logic [1:0] code);
    case (code)
      2'd1:    n_bytes = 3'd1;
      2'd2:    n_bytes = 3'd2;
      2'd3:    n_bytes = 3'd4;
      default: n_bytes = 3'd0;
    endcase
  endfunction

  always_comb begin
    host_push     = n_bytes(store_tx_data);
    host_pop      = n_bytes(get_rx_data);
    use_host_push = (store_tx_data != 2'd0);
    p_req         = use_host_push ? host_push : {2'b00, store_rx_packet_data};
    q_req         = (get_rx_data != 2'd0) ? host_pop : {2'b00, get_tx_packet_data};
    q             = ({5'b0, q_req} > occ) ? occ[2:0] : q_req;
    // Bytes popped this cycle free room for this cycle's push.
    free          = DEPTH_B - occ + {5'b0, q};
    p             = ({5'b0, p_req} > free) ? free[2:0] : p_req;
  end

  always_comb begin
    rx_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (8'(k) < occ) rx_data[8*k +: 8] = mem[rd_ptr + PTR_W'(k)];
    end
    tx_packet_data = (occ != 8'd0) ? mem[rd_ptr] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (n_rst && !clear_data_buffer) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < p)
          mem[wr_ptr + PTR_W'(i)] <= use_host_push ? tx_data[8*i +: 8] : rx_packet_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || clear_data_buffer) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= 8'd0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(q);
      wr_ptr <= wr_ptr + PTR_W'(p);
      occ    <= occ + {5'b0, p} - {5'b0, q};
    end
  end

  assign buffer_occupancy = occ;

`ifdef USB_DATA_BUFFER_ERR_EN
  logic drop_push;
  logic drop_pop;

  assign drop_push = (store_tx_data != 2'd0) && store_rx_packet_data;
  assign drop_pop  = (get_rx_data != 2'd0) && get_tx_packet_data;

  always_ff @(posedge clk) begin
    if (!n_rst || clear_data_buffer)
      buffer_error <= 1'b0;
    else if ((p < p_req) || (q < q_req) || drop_push || drop_pop)
      buffer_error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Bench for usb_data_buffer: directed steps plus random traffic against a byte-queue model.
module tb_usb_data_buffer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  get_rx_data;
  logic [1:0]  store_tx_data;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic        clear_data_buffer;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic [7:0]  buffer_occupancy;
`ifdef USB_DATA_BUFFER_ERR_EN
  logic        buffer_error;
`endif

  usb_data_buffer #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .get_rx_data          (get_rx_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .rx_data              (rx_data),
    .clear_data_buffer    (clear_data_buffer),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy)
`ifdef USB_DATA_BUFFER_ERR_EN
    ,
    .buffer_error         (buffer_error)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [7:0] exp_q[$];
  logic       exp_err;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int code_bytes(input logic [1:0] c);
    return (c == 2'd3) ? 4 : int'(c);
  endfunction

  function automatic logic [31:0] exp_peek();
    logic [31:0] v = 32'h0;
    for (int k = 0; k < 4; k++)
      if (k < exp_q.size()) v[8*k +: 8] = exp_q[k];
    return v;
  endfunction

  task automatic check_peeks(input string tag);
    check({tag, "_rx_data"}, rx_data, exp_peek());
    check({tag, "_tx_pkt"}, {24'h0, tx_packet_data}, {24'h0, (exp_q.size() != 0) ? exp_q[0] : 8'h00});
  endtask

  task automatic check_state(input string tag);
    check({tag, "_occ"}, {24'h0, buffer_occupancy}, 32'(exp_q.size()));
`ifdef USB_DATA_BUFFER_ERR_EN
    check({tag, "_err"}, {31'h0, buffer_error}, {31'h0, exp_err});
`endif
  endtask

  // Reference: a plain byte queue, updated with the counting rules of one edge.
  task automatic model_edge();
    int preq, qreq, pn, qn;
    logic host_push;
    if (!n_rst || clear_data_buffer) begin
      exp_q.delete();
      exp_err = 1'b0;
      return;
    end
    host_push = (store_tx_data != 2'd0);
    preq = host_push ? code_bytes(store_tx_data) : int'(store_rx_packet_data);
    qreq = (get_rx_data != 2'd0) ? code_bytes(get_rx_data) : int'(get_tx_packet_data);
    qn = (qreq < exp_q.size()) ? qreq : exp_q.size();
    for (int i = 0; i < qn; i++) void'(exp_q.pop_front());
    pn = (preq < DEPTH - exp_q.size()) ? preq : DEPTH - exp_q.size();
    for (int i = 0; i < pn; i++)
      exp_q.push_back(host_push ? tx_data[8*i +: 8] : rx_packet_data);
    if (pn < preq || qn < qreq || (host_push && store_rx_packet_data) ||
        (get_rx_data != 2'd0 && get_tx_packet_data))
      exp_err = 1'b1;
  endtask

  // driver: called #1 after a rising edge; drives, checks peeks, clocks, checks state
  task automatic step(input string tag, input logic [1:0] get, input logic [1:0] st,
                      input logic [31:0] txd, input logic clr, input logic srx,
                      input logic [7:0] rxb, input logic gtx, input logic rstn);
    get_rx_data          = get;
    store_tx_data        = st;
    tx_data              = txd;
    clear_data_buffer    = clr;
    store_rx_packet_data = srx;
    rx_packet_data       = rxb;
    get_tx_packet_data   = gtx;
    n_rst                = rstn;
    #1;
    check_peeks(tag);
    model_edge();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle_inputs();
    get_rx_data = 2'd0; store_tx_data = 2'd0; tx_data = 32'h0; clear_data_buffer = 1'b0;
    store_rx_packet_data = 1'b0; rx_packet_data = 8'h0; get_tx_packet_data = 1'b0;
  endtask

  initial begin
    idle_inputs();
    n_rst = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    check("reset_occ", {24'h0, buffer_occupancy}, 32'h0);
    check("reset_rx_data", rx_data, 32'h0);
    check("reset_tx_pkt", {24'h0, tx_packet_data}, 32'h0);
`ifdef USB_DATA_BUFFER_ERR_EN
    check("reset_err", {31'h0, buffer_error}, 32'h0);
`endif

    // host pushes 4, TX engine drains one per cycle
    step("push4", 2'd0, 2'd3, 32'hDDCCBBAA, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    check("push4_head", {24'h0, tx_packet_data}, 32'hAA);
    check("push4_occ", {24'h0, buffer_occupancy}, 32'd4);
    for (int i = 0; i < 4; i++)
      step("txpop", 2'd0, 2'd0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1);

    // RX engine bytes, host pops two
    step("rxb0", 2'd0, 2'd0, 32'h0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
    step("rxb1", 2'd0, 2'd0, 32'h0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    step("rxb2", 2'd0, 2'd0, 32'h0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
    step("rxb3", 2'd0, 2'd0, 32'h0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
    check("rx_peek4", rx_data, 32'h44332211);
    step("pop2", 2'd2, 2'd0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    check("pop2_occ", {24'h0, buffer_occupancy}, 32'd2);
    check("pop2_peek", rx_data, 32'h00004433);
    step("pop2b", 2'd2, 2'd0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    step("underflow", 2'd3, 2'd0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);

    // wrap: reset, move both pointers to 62, then 4 bytes straddle the end
    step("rst", 2'd0, 2'd0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step("adv_push", 2'd0, 2'd3, $urandom, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    step("adv_push2", 2'd0, 2'd2, $urandom, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step("adv_pop", 2'd3, 2'd0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    step("adv_pop2", 2'd2, 2'd0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    step("wrap_push", 2'd0, 2'd3, 32'h04030201, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    check("wrap_peek", rx_data, 32'h04030201);
    step("wrap_pop", 2'd3, 2'd0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    check("wrap_occ", {24'h0, buffer_occupancy}, 32'd0);

    // overflow near full
    for (int i = 0; i < 15; i++) step("fill", 2'd0, 2'd3, $urandom, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    step("fill2", 2'd0, 2'd2, $urandom, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    check("fill_occ", {24'h0, buffer_occupancy}, 32'd62);
    step("overflow", 2'd0, 2'd3, 32'hA5A4A3A2, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    check("overflow_occ", {24'h0, buffer_occupancy}, 32'd64);
`ifdef USB_DATA_BUFFER_ERR_EN
    check("overflow_err", {31'h0, buffer_error}, 32'h1);
`endif
    step("full_pushpop", 2'd3, 2'd3, 32'h99887766, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);

    // flush with simultaneous push, and clear held
    step("clr0", 2'd0, 2'd0, 32'h0, 1'b1, 1'b0, 8'h0, 1'b0, 1'b1);
    step("p10a", 2'd0, 2'd3, $urandom, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    step("p10b", 2'd0, 2'd3, $urandom, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    step("p10c", 2'd0, 2'd2, $urandom, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    check("occ10", {24'h0, buffer_occupancy}, 32'd10);
    step("clr_push", 2'd0, 2'd3, 32'h12345678, 1'b1, 1'b0, 8'h0, 1'b0, 1'b1);
    check("clr_occ", {24'h0, buffer_occupancy}, 32'd0);
    check("clr_peek", rx_data, 32'h0);
    step("clr_hold", 2'd1, 2'd1, 32'h0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);

    // random traffic, including collisions, clears and resets
    for (int n = 0; n < 400; n++) begin
      step("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 99) != 0));
    end

    idle_inputs();
    n_rst = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_data_buffer.md
Name: usb_data_buffer

Overview:
- Shared byte-wide FIFO between the AHB slave interface and the USB RX/TX packet engines.
- Host side: pushes 1/2/4 bytes per cycle (TX payload) and pops 1/2/4 bytes per cycle (RX payload).
- Packet side: pushes one received byte per cycle from the RX engine and pops one byte per cycle to the TX engine.
- Reports live occupancy and supports a single-cycle flush.

Parameters:
DEPTH, 64, capacity in bytes; power of two, 4..128
PTR_W, $clog2(DEPTH), read/write pointer width

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset, synchronous, active-low
get_rx_data  input  2  host pop: 0 none, 1 one byte, 2 two bytes, 3 four bytes
store_tx_data  input  2  host push: same encoding as get_rx_data
tx_data  input  32  host push data; byte0 = [7:0] is oldest
rx_data  output  32  head-of-FIFO peek; byte0 = oldest
clear_data_buffer  input  1  flush request
store_rx_packet_data  input  1  RX engine pushes one byte
rx_packet_data  input  8  RX engine byte
get_tx_packet_data  input  1  TX engine pops one byte
tx_packet_data  output  8  head byte for TX engine
buffer_occupancy  output  8  bytes currently stored, 0..DEPTH

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-low: on a rising clk edge with n_rst=0, rd_ptr=0, wr_ptr=0, occupancy=0.
  - Storage contents are not reset.
- Read peeks (combinational, no latency):
  - rx_data byte k = mem[rd_ptr+k] when k < occupancy, else 8'h00.
  - tx_packet_data = mem[rd_ptr] when occupancy != 0, else 8'h00.
  - The AHB slave registers rx_data in the same cycle it asserts get_rx_data. Peek data must therefore be valid before the pop edge; the pop takes effect at that edge.
- Counts per cycle:
  - Requested push count P_req = bytes(store_tx_data), or 1 if store_rx_packet_data and store_tx_data==0.
  - Requested pop count Q_req = bytes(get_rx_data), or 1 if get_tx_packet_data and get_rx_data==0.
  - Host requests win. A simultaneous packet-side request of the same direction is dropped and counts as an error.
- Pop and push limits:
  - Pop: Q = min(Q_req, occupancy). Underflow pops only the available bytes.
  - Push: P = min(P_req, DEPTH - occupancy + Q). Pops free space in the same cycle. Excess bytes are discarded, lowest-index bytes kept.
- Pointer and occupancy update:
  - Write bytes tx_data[8i+7:8i] (or rx_packet_data) to mem[wr_ptr+i] for i < P.
  - wr_ptr += P, rd_ptr += Q, both modulo DEPTH (natural PTR_W wrap).
  - occupancy_next = occupancy + P - Q, computed 8 bits wide, never exceeding DEPTH.
  - buffer_occupancy is the registered occupancy; it updates the cycle after the edge.
- Flush:
  - clear_data_buffer=1 at an edge sets rd_ptr=wr_ptr=0 and occupancy=0.
  - It overrides any push or pop in that same cycle (those are discarded).
  - The slave holds clear high until occupancy reads 0; the buffer must tolerate clear held for multiple cycles.
- Wrap-around: a 4-byte push or pop that crosses the DEPTH-1 -> 0 boundary splits correctly across the end of memory.
- Reset mid-operation: in-flight requests are discarded and the FIFO is empty the next cycle.

Optional Feature:
- Macro: USB_DATA_BUFFER_ERR_EN.
- When defined: adds output buffer_error (1 bit, reset 0), a sticky flag set on any of:
  - overflow (P < P_req)
  - underflow (Q < Q_req)
  - dropped simultaneous packet-side request
  - Cleared only by clear_data_buffer or reset.
- When undefined: no port, no error logic; truncation behaviour is unchanged.

Test Plan:
- Reset then idle -> buffer_occupancy=0, rx_data=32'h0, tx_packet_data=8'h0.
- store_tx_data=3, tx_data=32'hDDCCBBAA; then get_tx_packet_data for 4 cycles -> tx_packet_data AA,BB,CC,DD; occupancy 4,3,2,1,0.
- Four store_rx_packet_data bytes 11,22,33,44, then get_rx_data=2 -> rx_data=32'h44332211 before the edge; occupancy 2 after; next peek 32'h00004433.
- Fill to 62 bytes, then store_tx_data=3 -> only 2 bytes stored, occupancy 64; with ERR_EN, buffer_error=1.
- Advance pointers to 62, push 4 bytes 01..04, pop 4 -> rx_data=32'h04030201 across the wrap.
- occupancy 10 with clear_data_buffer=1 and store_tx_data=3 in the same cycle -> occupancy 0, rx_data=0, push discarded.
